// File: rtl/oddr_tap_ctrl_pkg.sv
// Shared definitions for the DDR output tap controller: tap bus width,
// wait-counter width and the tap-move FSM state encoding.
package oddr_tap_ctrl_pkg;

    localparam int TAP_W = 9;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VTC_OFF,
        S_STEP,
        S_GAP,
        S_VTC_ON
    } tap_state_e;

endpackage

// File: rtl/oddr_tap_fsm.sv
// Tap-move controller: accepts a tap request, pauses VT compensation,
// walks the output delay one tap at a time, then restores VT compensation.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | ready for a request; en_vtc high
// S_VTC_OFF | en_vtc low, settling VTC_WAIT cycles before the first step
// S_STEP    | ce high for this one cycle; tap_cur moves at the end of it
// S_GAP     | STEP_GAP idle cycles after a step, then step again or finish
// S_VTC_ON  | en_vtc high again, settling VTC_WAIT cycles; done on exit
module oddr_tap_fsm
    import oddr_tap_ctrl_pkg::*;
#(
    parameter int TAP_MAX  = 511,
    parameter int VTC_WAIT = 10,
    parameter int STEP_GAP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tap_valid,
    output logic             tap_ready,
    input  logic [TAP_W-1:0] tap_value,
    output logic [TAP_W-1:0] tap_cur,
    output logic             busy,
    output logic             done,
    output logic             ce,
    output logic             inc,
    output logic             en_vtc
);

    localparam logic [TAP_W-1:0] TAP_MAX_C = TAP_W'(TAP_MAX);
    localparam logic [CNT_W-1:0] VW_LOAD   = CNT_W'(VTC_WAIT);
    // GAP is entered one cycle after STEP, so it counts one fewer.
    localparam logic [CNT_W-1:0] SG_LOAD   = CNT_W'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);

    tap_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [TAP_W-1:0] target;
    logic [TAP_W-1:0] req_clamped;
    logic [TAP_W-1:0] step_tap;

    assign tap_ready   = (state == S_IDLE);
    assign req_clamped = (tap_value > TAP_MAX_C) ? TAP_MAX_C : tap_value;

    always_comb begin
        step_tap = tap_cur;
        if (inc && (tap_cur != TAP_MAX_C)) begin
            step_tap = tap_cur + 1'b1;
        end else if (!inc && (tap_cur != '0)) begin
            step_tap = tap_cur - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            target  <= '0;
            tap_cur <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ce      <= 1'b0;
            inc     <= 1'b0;
            en_vtc  <= 1'b1;
        end else begin
            done <= 1'b0;
            ce   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tap_valid) begin
                        if (req_clamped == tap_cur) begin
                            done <= 1'b1;
                        end else begin
                            target <= req_clamped;
                            busy   <= 1'b1;
                            en_vtc <= 1'b0;
                            cnt    <= VW_LOAD;
                            state  <= S_VTC_OFF;
                        end
                    end
                end
                S_VTC_OFF: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= S_STEP;
                        ce    <= 1'b1;
                        inc   <= (target > tap_cur);
                    end
                end
                S_STEP: begin
                    tap_cur <= step_tap;
                    if (STEP_GAP == 0) begin
                        if (step_tap == target) begin
                            state  <= S_VTC_ON;
                            en_vtc <= 1'b1;
                            cnt    <= VW_LOAD;
                        end else begin
                            state <= S_STEP;
                            ce    <= 1'b1;
                            inc   <= (target > step_tap);
                        end
                    end else begin
                        state <= S_GAP;
                        cnt   <= SG_LOAD;
                    end
                end
                S_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (tap_cur == target) begin
                        state  <= S_VTC_ON;
                        en_vtc <= 1'b1;
                        cnt    <= VW_LOAD;
                    end else begin
                        state <= S_STEP;
                        ce    <= 1'b1;
                        inc   <= (target > tap_cur);
                    end
                end
                S_VTC_ON: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    en_vtc <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/oddr_tap_ctrl.sv
// Output DDR register with a shared, FSM-controlled output delay tap.
// The data path runs freely; only the delay line is touched during a move.
module oddr_tap_ctrl
    import oddr_tap_ctrl_pkg::*;
#(
    parameter string TARGET   = "GENERIC",
    parameter int    WIDTH    = 1,
    parameter int    TAP_MAX  = 511,
    parameter int    VTC_WAIT = 10,
    parameter int    STEP_GAP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q,
    input  logic             tap_valid,
    output logic             tap_ready,
    input  logic [TAP_W-1:0] tap_value,
    output logic [TAP_W-1:0] tap_cur,
    output logic             busy,
    output logic             done
);

    logic ce;
    logic inc;
    logic en_vtc;

    oddr_tap_fsm #(
        .TAP_MAX  (TAP_MAX),
        .VTC_WAIT (VTC_WAIT),
        .STEP_GAP (STEP_GAP)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_value (tap_value),
        .tap_cur   (tap_cur),
        .busy      (busy),
        .done      (done),
        .ce        (ce),
        .inc       (inc),
        .en_vtc    (en_vtc)
    );

    // The fabric model has no delay line, so the tap controls go nowhere there.
    logic unused_ctrl;
    assign unused_ctrl = ^{ce, inc, en_vtc};
    localparam bit unused_target = (TARGET == "XILINX");

    // Vendor primitives are only elaborated when the unisim library is compiled in.
`ifdef ODDR_TAP_UNISIM
    if (TARGET == "XILINX") begin : g_xilinx
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic oddr_q;

            ODDRE1 u_oddr (
                .Q  (oddr_q),
                .C  (clk),
                .D1 (d1[i]),
                .D2 (d2[i]),
                .SR (~rst_n)
            );

            ODELAYE3 #(
                .DELAY_FORMAT ("COUNT"),
                .DELAY_TYPE   ("VARIABLE"),
                .DELAY_VALUE  (0)
            ) u_odly (
                .CASC_OUT    (),
                .CNTVALUEOUT (),
                .DATAOUT     (q[i]),
                .CASC_IN     (1'b0),
                .CASC_RETURN (1'b0),
                .CE          (ce),
                .CLK         (clk),
                .CNTVALUEIN  (9'd0),
                .EN_VTC      (en_vtc),
                .INC         (inc),
                .LOAD        (1'b0),
                .ODATAIN     (oddr_q),
                .RST         (~rst_n)
            );
        end
    end else
`endif
    begin : g_generic
        logic [WIDTH-1:0] d1_reg;
        logic [WIDTH-1:0] d2_reg;
        logic [WIDTH-1:0] d2_neg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                d1_reg <= '0;
                d2_reg <= '0;
            end else begin
                d1_reg <= d1;
                d2_reg <= d2;
            end
        end

        // Retimed to the falling edge so d2 is stable for the whole low phase.
        always_ff @(negedge clk) begin
            d2_neg <= d2_reg;
        end

        assign q = clk ? d1_reg : d2_neg;
    end

endmodule
